// File: rtl/uart_rx_path.sv
// 8N1 UART receiver: synchronizes the line, samples each bit at mid-bit, flags framing errors.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx_path #(
  parameter logic [13:0] BAUD_DIV     = 14'd10416,
  parameter logic [13:0] BAUD_DIV_CAP = 14'd5208
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       uart_rx_i,
  output logic [7:0] uart_rx_data_o,
  output logic       uart_rx_done,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_parity_err,
  output logic       uart_rx_busy
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic [13:0] r_baud_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
`ifdef UART_RX_PARITY_EN
  logic        r_par_bit;
`endif

  logic w_fall;
  logic w_cap_hit;
  logic w_bit_hit;

  // r_sync2 is the synchronized line; r_sync3 holds its previous value.
  assign w_fall    = r_sync3 & ~r_sync2;
  assign w_cap_hit = (r_baud_cnt == (BAUD_DIV_CAP - 14'd1));
  assign w_bit_hit = (r_baud_cnt == (BAUD_DIV - 14'd1));

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state           <= StIdle;
      r_sync1           <= 1'b1;
      r_sync2           <= 1'b1;
      r_sync3           <= 1'b1;
      r_baud_cnt        <= 14'd0;
      r_bit_cnt         <= 3'd0;
      r_shift           <= 8'h00;
      uart_rx_data_o    <= 8'h00;
      uart_rx_done      <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit          <= 1'b0;
      uart_rx_parity_err <= 1'b0;
`endif
    end else begin
      r_sync1           <= uart_rx_i;
      r_sync2           <= r_sync1;
      r_sync3           <= r_sync2;
      uart_rx_done      <= 1'b0;
      uart_rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      uart_rx_parity_err <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          r_baud_cnt   <= 14'd0;
          uart_rx_busy <= 1'b0;
          if (w_fall) begin
            r_state      <= StStart;
            uart_rx_busy <= 1'b1;
          end
        end
        StStart: begin
          if (w_cap_hit) begin
            r_baud_cnt <= 14'd0;
            if (!r_sync2) begin
              r_state   <= StData;
              r_bit_cnt <= 3'd0;
            end else begin
              // Line went back high before mid-start: a glitch, not a frame.
              r_state      <= StIdle;
              uart_rx_busy <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 14'd1;
          end
        end
        StData: begin
          if (w_bit_hit) begin
            r_baud_cnt         <= 14'd0;
            r_shift[r_bit_cnt] <= r_sync2;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= StParity;
`else
              r_state <= StStop;
`endif
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 14'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (w_bit_hit) begin
            r_baud_cnt <= 14'd0;
            r_par_bit  <= r_sync2;
            r_state    <= StStop;
          end else begin
            r_baud_cnt <= r_baud_cnt + 14'd1;
          end
        end
`endif
        StStop: begin
          if (w_bit_hit) begin
            r_baud_cnt <= 14'd0;
            if (r_sync2) begin
              // Leave at mid-stop so a back-to-back start edge is not missed.
              uart_rx_data_o <= r_shift;
              uart_rx_done   <= 1'b1;
              uart_rx_busy   <= 1'b0;
              r_state        <= StIdle;
`ifdef UART_RX_PARITY_EN
              uart_rx_parity_err <= (^r_shift) ^ r_par_bit;
`endif
            end else begin
              uart_rx_frame_err <= 1'b1;
              r_state           <= StBreak;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 14'd1;
          end
        end
        StBreak: begin
          r_baud_cnt <= 14'd0;
          if (r_sync2) begin
            r_state      <= StIdle;
            uart_rx_busy <= 1'b0;
          end
        end
        default: begin
          r_state      <= StIdle;
          r_baud_cnt   <= 14'd0;
          uart_rx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign uart_rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_path.md
Name: uart_rx_path

Overview:
- UART receiver, 8N1, LSB first. Counterpart of the team's UART transmit path; same baud parameters, so the two blocks pair directly.
- Synchronizes the asynchronous serial line and samples each bit at mid-bit.
- Presents the received byte with a one-cycle done pulse and flags framing errors.
- Sits between the board RX pin and the command/telemetry logic of the tracker.

Parameters:
- BAUD_DIV, 14'd10416, clock cycles per bit (100 MHz / 9600 bps).
- BAUD_DIV_CAP, 14'd5208, cycles from start-edge detection to the mid-start-bit sample.

Ports:
- iclk  input  1  system clock, 100 MHz.
- irst  input  1  reset, synchronous, active-high.
- uart_rx_i  input  1  asynchronous serial line; idles high.
- uart_rx_data_o  output  8  last correctly received byte.
- uart_rx_done  output  1  one-cycle pulse; uart_rx_data_o is valid from this cycle onward.
- uart_rx_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- uart_rx_parity_err  output  1  one-cycle parity-error pulse (see Optional Feature).
- uart_rx_busy  output  1  high in any state except IDLE.

Behaviour:
- Reset, on an iclk edge with irst=1:
  - uart_rx_data_o=8'h00; done, frame_err, parity_err and busy all 0.
  - Synchronizer flops=1; baud_cnt=0; bit_cnt=0; state=IDLE.
  - Reset mid-frame aborts the frame with no pulse.
- Input synchronization: 2-flop synchronizer, then a third flop for edge detection. A falling edge means prev=1 and cur=0 on the synchronized signal.
- baud_cnt is 14 bits. It is cleared on every state transition and at every sample point.
- IDLE:
  - busy=0.
  - A falling edge goes to START with baud_cnt=0.
- START:
  - baud_cnt increments each cycle.
  - At baud_cnt==BAUD_DIV_CAP-1, sample the line: low goes to DATA (bit_cnt=0); high is a glitch and returns to IDLE with no pulse.
- DATA:
  - baud_cnt increments each cycle.
  - At baud_cnt==BAUD_DIV-1, sample into shift_reg[bit_cnt] (LSB first) and increment bit_cnt.
  - After the sample with bit_cnt==7, go to PARITY if the feature is enabled, otherwise to STOP.
- STOP:
  - Sample at baud_cnt==BAUD_DIV-1.
  - High: on the next cycle load uart_rx_data_o=shift_reg, pulse done for 1 cycle, go to IDLE. Returning to IDLE at mid-stop lets a back-to-back start bit be caught.
  - Low: on the next cycle pulse frame_err for 1 cycle, leave uart_rx_data_o unchanged, go to BREAK.
- BREAK:
  - Wait until the synchronized line is high, then go to IDLE. A held-low line therefore gives exactly one frame_err.
- Latency: done rises 1 cycle after the stop-bit sample. That is BAUD_DIV_CAP + 9*BAUD_DIV + 1 cycles after start-edge detection, plus 3 cycles of input synchronization.
- Simultaneous events: irst has priority over everything. done and frame_err are never high together.
- Line edges while in START, DATA or STOP are ignored; only the scheduled samples matter.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: one even-parity bit between data and stop.
  - PARITY state samples it at baud_cnt==BAUD_DIV-1, then goes to STOP.
  - If (^shift_reg ^ parity_bit)==1, parity_err pulses 1 cycle together with done, and uart_rx_data_o is still updated.
  - Latency grows by BAUD_DIV.
- Undefined: no PARITY state exists and uart_rx_parity_err is tied to 0.

Test Plan:
- Bench parameters: BAUD_DIV=16, BAUD_DIV_CAP=8 unless stated.
- Basic receive: hold line high 50 cycles, then send 0x55 in 8N1 at 16 cycles/bit -> exactly one done pulse; uart_rx_data_o=8'h55; frame_err=0; busy falls in the same cycle done rises.
- Back-to-back: send 0xA3 then immediately 0x0F with no idle gap -> two done pulses, data 8'hA3 then 8'h0F.
- Framing error: send 0xC4 with stop bit low, hold line low 100 cycles, then release -> one frame_err pulse, no done, uart_rx_data_o keeps its prior value, new frame accepted afterwards.
- Glitch rejection: line low for 4 cycles, then high -> no done, state back at IDLE, busy low again before 12 cycles.
- Reset mid-frame: assert irst for 1 cycle during bit 3 of 0x81, then send 0x3C -> no pulses from the aborted frame, outputs zero after reset, then done with 8'h3C.
- Parity (with UART_RX_PARITY_EN): send 0x07 with parity bit 1 -> done and parity_err=0; send 0x07 with parity bit 0 -> done and parity_err pulse together, data=8'h07.
